// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit:
// op encodings, FSM states and iteration constants.
package muldiv_pkg;

   localparam int XLEN = 32;
   localparam logic [4:0] ITER_LAST = 5'd31;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_t;

   function automatic logic isDivOp(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration shared by multiply (shift-add) and
// divide (restoring shift-subtract).
// Ports: accIn/qmIn current partial state, opnd multiplicand or
// divisor, op selects mult/div; accOut/qmOut next partial state.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0] accIn,
   input  logic [XLEN-1:0] qmIn,
   input  logic [XLEN-1:0] opnd,
   input  logic [1:0]      op,
   output logic [XLEN-1:0] accOut,
   output logic [XLEN-1:0] qmOut
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem;
   logic [XLEN:0] diff;

   always_comb begin
      sum    = {1'b0, accIn} + {1'b0, opnd};
      rem    = {accIn, qmIn[XLEN-1]};
      diff   = rem - {1'b0, opnd};
      accOut = accIn;
      qmOut  = qmIn;
      if (isDivOp(op)) begin
         // Borrow out of the top bit means the trial subtract failed.
         if (!diff[XLEN]) begin
            accOut = diff[XLEN-1:0];
            qmOut  = {qmIn[XLEN-2:0], 1'b1};
         end else begin
            accOut = rem[XLEN-1:0];
            qmOut  = {qmIn[XLEN-2:0], 1'b0};
         end
      end else begin
         // Product accumulates in acc; multiplier drains out of qm's LSB.
         if (qmIn[0])
            {accOut, qmOut} = {sum, qmIn[XLEN-1:1]};
         else
            {accOut, qmOut} = {1'b0, accIn, qmIn[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage iterative multiply/divide with HI/LO registers.
// Ports: CLK, RST (sync, active-high), WriteLoHiE start, MDOpE op,
// SrcAE/SrcBE operands, ReadHiE/ReadLoE MFHI/MFLO select,
// HiLoOutE read data, BusyE stall request.
// Build option: HILO_FAST_MULT_EN gives single-cycle multiplies.
module hilo_muldiv
   import muldiv_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            WriteLoHiE,
   input  logic [1:0]      MDOpE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            ReadHiE,
   input  logic            ReadLoE,
   output logic [XLEN-1:0] HiLoOutE,
   output logic            BusyE
);

   state_t          state;
   logic [4:0]      count;
   logic [1:0]      op;
   logic            signA, signB;
   logic [XLEN-1:0] acc, qm, opnd, rawA;
   logic [XLEN-1:0] hi, lo;
   logic [XLEN-1:0] accNext, qmNext;

   logic            isSignedIn;
   logic            negA, negB;
   logic [XLEN-1:0] absA, absB;
   logic [63:0]     prodFix;
   logic [XLEN-1:0] quot, rem;

   assign isSignedIn = (MDOpE == MD_MULT) || (MDOpE == MD_DIV);
   assign negA = isSignedIn & SrcAE[XLEN-1];
   assign negB = isSignedIn & SrcBE[XLEN-1];
   assign absA = negA ? -SrcAE : SrcAE;
   assign absB = negB ? -SrcBE : SrcBE;

   // Unsigned ops latch zero signs, so these fixups are no-ops for them.
   assign prodFix = (signA ^ signB) ? -{acc, qm} : {acc, qm};
   assign quot    = (signA ^ signB) ? -qm : qm;
   assign rem     = signA ? -acc : acc;

`ifdef HILO_FAST_MULT_EN
   logic [63:0] extA, extB, fastProd;
   assign extA     = {{32{negA}}, SrcAE};
   assign extB     = {{32{negB}}, SrcBE};
   assign fastProd = extA * extB;
`endif

   muldiv_step uStep (
      .accIn (acc),
      .qmIn  (qm),
      .opnd  (opnd),
      .op    (op),
      .accOut(accNext),
      .qmOut (qmNext)
   );

   assign BusyE = (state != S_IDLE);

   always_comb begin
      HiLoOutE = '0;
      if (ReadHiE)
         HiLoOutE = hi;
      else if (ReadLoE)
         HiLoOutE = lo;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         count <= '0;
         op    <= MD_MULT;
         signA <= 1'b0;
         signB <= 1'b0;
         acc   <= '0;
         qm    <= '0;
         opnd  <= '0;
         rawA  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (WriteLoHiE) begin
`ifdef HILO_FAST_MULT_EN
                  if (!isDivOp(MDOpE)) begin
                     {hi, lo} <= fastProd;
                  end else begin
`else
                  begin
`endif
                     op    <= MDOpE;
                     signA <= negA;
                     signB <= negB;
                     acc   <= '0;
                     qm    <= absA;
                     opnd  <= absB;
                     rawA  <= SrcAE;
                     count <= '0;
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               acc   <= accNext;
               qm    <= qmNext;
               count <= count + 5'd1;
               if (count == ITER_LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               if (!isDivOp(op))
                  {hi, lo} <= prodFix;
               else if (opnd == '0)
                  {hi, lo} <= {rawA, {XLEN{1'b1}}};
               else
                  {hi, lo} <= {rem, quot};
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed + scoreboard bench for hilo_muldiv.
module tb_hilo_muldiv;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WriteLoHiE;
   logic [1:0]  MDOpE;
   logic [31:0] SrcAE, SrcBE;
   logic        ReadHiE, ReadLoE;
   logic [31:0] HiLoOutE;
   logic        BusyE;

   int nAsserts = 0;
   int nFail    = 0;

   logic [31:0] sbHi[$];
   logic [31:0] sbLo[$];
   string       sbTag[$];
   logic [31:0] curHi = 32'd0;
   logic [31:0] curLo = 32'd0;

   always #5 CLK = ~CLK;

   hilo_muldiv dut (
      .CLK       (CLK),
      .RST       (RST),
      .WriteLoHiE(WriteLoHiE),
      .MDOpE     (MDOpE),
      .SrcAE     (SrcAE),
      .SrcBE     (SrcBE),
      .ReadHiE   (ReadHiE),
      .ReadLoE   (ReadLoE),
      .HiLoOutE  (HiLoOutE),
      .BusyE     (BusyE)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkRead(input string tag, input logic [31:0] eHi,
                            input logic [31:0] eLo);
      ReadHiE = 1'b1; ReadLoE = 1'b0; #1;
      chk({tag, ".hi"}, HiLoOutE, eHi);
      ReadHiE = 1'b0; ReadLoE = 1'b1; #1;
      chk({tag, ".lo"}, HiLoOutE, eLo);
      ReadHiE = 1'b1; ReadLoE = 1'b1; #1;
      chk({tag, ".both"}, HiLoOutE, eHi);
      ReadHiE = 1'b0; ReadLoE = 1'b0; #1;
      chk({tag, ".none"}, HiLoOutE, 32'd0);
   endtask

   function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] res;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      res = 64'd0;
      case (op)
         2'b00: res = sa * sb;
         2'b01: res = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) res = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFFFFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Starts an op at the next edge, measures BusyE, then drains the
   // scoreboard and checks the architectural read path.
   task automatic runOp(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eHi, input logic [31:0] eLo);
      int cnt;
      int expBusy;
      logic [31:0] pHi, pLo;
      string pTag;
      expBusy = 33;
`ifdef HILO_FAST_MULT_EN
      if (!op[1]) expBusy = 0;
`endif
      sbHi.push_back(eHi);
      sbLo.push_back(eLo);
      sbTag.push_back(tag);
      MDOpE = op; SrcAE = a; SrcBE = b; WriteLoHiE = 1'b1;
      @(posedge CLK); #1;
      WriteLoHiE = 1'b0;
      cnt = 0;
      while (BusyE === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == 33) begin
            ReadLoE = 1'b1; #1;
            chk({tag, ".fixOld"}, HiLoOutE, curLo);
            ReadLoE = 1'b0;
         end
         @(posedge CLK); #1;
      end
      chk({tag, ".busy"}, cnt, expBusy);
      pHi = sbHi.pop_front();
      pLo = sbLo.pop_front();
      pTag = sbTag.pop_front();
      checkRead(pTag, pHi, pLo);
      curHi = pHi;
      curLo = pLo;
   endtask

   initial begin
      logic [63:0] m;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      RST = 1'b1; WriteLoHiE = 1'b0; MDOpE = 2'b00;
      SrcAE = '0; SrcBE = '0; ReadHiE = 1'b0; ReadLoE = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst.busy", {31'd0, BusyE}, 32'd0);
      checkRead("rst", 32'd0, 32'd0);
      RST = 1'b0;

      runOp("mult7xm3", 2'b00, 32'd7, 32'hFFFFFFFD,
            32'hFFFFFFFF, 32'hFFFFFFEB);
      runOp("divu100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      runOp("divm7d2", 2'b10, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("divOvf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
            32'd0, 32'h80000000);
      runOp("divuZero", 2'b11, 32'h1234, 32'd0,
            32'h1234, 32'hFFFFFFFF);
      runOp("divZeroNeg", 2'b10, 32'hFFFFFFFB, 32'd0,
            32'hFFFFFFFB, 32'hFFFFFFFF);
      runOp("multuBig", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);

      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (i == 5) ra = 32'hF0000000;
         m = model(rop, ra, rb);
         runOp($sformatf("rnd%0d", i), rop, ra, rb, m[63:32], m[31:0]);
      end

      MDOpE = 2'b01; SrcAE = 32'h0000FFFF; SrcBE = 32'h00001234;
      WriteLoHiE = 1'b1;
      @(posedge CLK); #1;
      WriteLoHiE = 1'b0;
      repeat (9) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("abort.busy", {31'd0, BusyE}, 32'd0);
      checkRead("abort", 32'd0, 32'd0);
      repeat (40) @(posedge CLK);
      #1;
      chk("abort.later.busy", {31'd0, BusyE}, 32'd0);
      checkRead("abort.later", 32'd0, 32'd0);
      curHi = 32'd0;
      curLo = 32'd0;

      runOp("prio59d6", 2'b11, 32'd59, 32'd6, 32'd5, 32'd9);
      ReadHiE = 1'b1; ReadLoE = 1'b1; #1;
      chk("prio.hiWins", HiLoOutE, 32'd5);
      ReadHiE = 1'b0; ReadLoE = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               nAsserts, nFail);
      $finish;
   end

endmodule
